// File: rtl/fifo_packer_if.sv
// Bundle of both handshakes of the packer: the FIFO consumer side and the wide sink side.
// The slave modport is the packer's view; the master modport is the environment's view.
interface fifo_packer_if #(
  parameter int W  = 3,
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
);
  logic           f2c_irdy;
  logic           c2f_trdy;
  logic [W-1:0]   data_in;
  logic           flush_req;
  logic           pk2s_irdy;
  logic           s2pk_trdy;
  logic [N*W-1:0] data_out;
  logic [CW-1:0]  out_cnt;

  modport slave (
    input  f2c_irdy, data_in, flush_req, s2pk_trdy,
    output c2f_trdy, pk2s_irdy, data_out, out_cnt
  );

  modport master (
    output f2c_irdy, data_in, flush_req, s2pk_trdy,
    input  c2f_trdy, pk2s_irdy, data_out, out_cnt
  );
endinterface

// File: rtl/fifo_packer.sv
// Packs N consecutive FIFO entries into one wide word (lane 0 = oldest),
// with on-demand flush of partial words and lossless backpressure to the FIFO.
module fifo_packer #(
  parameter type T = logic [2:0],
  parameter int  N = 4
) (
  input logic          clk,
  input logic          rst,
  fifo_packer_if.slave bus
);
  localparam int W    = $bits(T);
  localparam int LOGN = $clog2(N);
  localparam int CW   = $clog2(N + 1);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  logic [W-1:0]    acc_reg [N-1];
  logic [LOGN-1:0] idx_reg;
  logic            flush_pend_reg;
  logic            out_valid_reg;
  logic [N*W-1:0]  data_out_reg;
  logic [CW-1:0]   out_cnt_reg;

  logic [N*W-1:0]  full_word;
  logic [N*W-1:0]  part_word;
  logic            out_free;
  logic            accept;
  logic            complete;
  logic            flush_emit;
  logic            drain;

  assign out_free     = !out_valid_reg || bus.s2pk_trdy;
  assign bus.c2f_trdy = rst && !flush_pend_reg && !(idx_reg == LAST && !out_free);
  assign accept       = bus.f2c_irdy && bus.c2f_trdy;
  assign complete     = accept && (idx_reg == LAST);
  assign flush_emit   = flush_pend_reg && (idx_reg != '0) && out_free;
  assign drain        = out_valid_reg && bus.s2pk_trdy;

  assign bus.pk2s_irdy = out_valid_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.out_cnt   = out_cnt_reg;

  // Lane wiring: the completing entry goes straight into the top lane; partial
  // words zero every lane at or above the current fill level.
  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_lane
      localparam logic [LOGN-1:0] LANE = LOGN'(gi);
      assign full_word[gi*W +: W] = acc_reg[gi];
      assign part_word[gi*W +: W] = (LANE < idx_reg) ? acc_reg[gi] : '0;
    end
  endgenerate
  assign full_word[(N-1)*W +: W] = bus.data_in;
  assign part_word[(N-1)*W +: W] = '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N - 1; k++) acc_reg[k] <= '0;
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        if (accept && idx_reg == LOGN'(k)) acc_reg[k] <= bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg        <= '0;
      flush_pend_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      data_out_reg   <= '0;
      out_cnt_reg    <= '0;
    end else begin
      // complete and flush_emit never coincide: a pending flush blocks accepts.
      if (complete) begin
        data_out_reg  <= full_word;
        out_cnt_reg   <= CW'(N);
        out_valid_reg <= 1'b1;
        idx_reg       <= '0;
      end else if (flush_emit) begin
        data_out_reg  <= part_word;
        out_cnt_reg   <= CW'(idx_reg);
        out_valid_reg <= 1'b1;
        idx_reg       <= '0;
      end else begin
        if (accept) idx_reg <= idx_reg + 1'b1;
        if (drain)  out_valid_reg <= 1'b0;
      end

      if (flush_pend_reg) begin
        if (idx_reg == '0 || out_free) flush_pend_reg <= 1'b0;
      end else if (bus.flush_req) begin
        flush_pend_reg <= 1'b1;
      end
    end
  end
endmodule

// File: doc/fifo_packer.md
Name: fifo_packer

Overview:
- Downstream neighbour of the FIFO: consumes single entries from the FIFO's consumer port (irdy/trdy handshake) and packs N consecutive entries into one wide word for the next stage.
- Partial words are emitted on request via a flush input; the number of valid lanes accompanies every word.
- Backpressure from the wide side propagates to the FIFO through c2f_trdy without losing or reordering entries.

Parameters:
- T, logic[2:0], type of one FIFO entry; W = $bits(T).
- N, 4, entries per packed word; legal N >= 2.
- LOGN (localparam), $clog2(N), width of the lane index.
- CW (localparam), $clog2(N+1), width of out_cnt.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state while low.
- f2c_irdy  input  1  FIFO has a valid entry on data_in.
- c2f_trdy  output  1  packer accepts the entry this cycle.
- data_in  input  W  entry from the FIFO.
- flush_req  input  1  request to emit the current partial word.
- pk2s_irdy  output  1  packed word valid on data_out.
- s2pk_trdy  input  1  sink accepts the packed word.
- data_out  output  N*W  packed word; lane k is data_out[k*W +: W].
- out_cnt  output  CW  number of valid lanes in data_out, 1..N.

Behaviour:
- Transfer rule (both sides): a transfer occurs in a cycle where irdy && trdy, sampled at the rising edge. Once pk2s_irdy is high, it stays high and data_out/out_cnt stay stable until the transfer.
- Internal state:
  - acc: (N-1) x W accumulator.
  - idx: 0..N-1, entries currently held in acc.
  - flush_pend: flush request latched, not yet processed.
  - Output register: data_out, out_cnt, out_valid; pk2s_irdy = out_valid.
- Output free condition: out_free = !out_valid || s2pk_trdy.
- c2f_trdy (combinational from registered state and s2pk_trdy only): rst && !flush_pend && !(idx==N-1 && !out_free).
- Accept, idx < N-1: acc[idx] <= data_in; idx <= idx+1.
- Accept, idx == N-1 (completing entry):
  - data_out <= {data_in, acc[N-2..0]}, so lane 0 = oldest entry.
  - out_cnt <= N; out_valid <= 1; idx <= 0.
  - Latency: the word is visible the cycle after the completing accept.
- flush_req high at an edge: flush_pend <= 1.
  - An entry accepted in that same cycle is included in the flush.
  - flush_req while flush_pend is already 1 has no further effect.
- While flush_pend == 1 (no accepts possible), evaluated each cycle:
  - idx == 0: clear flush_pend; no word emitted.
  - idx > 0 and out_free: data_out lanes 0..idx-1 <= acc, remaining lanes <= 0; out_cnt <= idx; out_valid <= 1; idx <= 0; clear flush_pend.
  - idx > 0 and !out_free: hold and retry next cycle.
  - Earliest partial word is visible 2 cycles after flush_req.
- flush_req in the same cycle as the completing accept: the full word is emitted (out_cnt = N); the next cycle clears flush_pend with no extra word.
- Output drain:
  - On an output transfer with no new word loaded, out_valid <= 0.
  - If a new word is loaded in the same cycle as the drain, out_valid stays 1 and the new word replaces the old one. This gives back-to-back full throughput of one entry per cycle.
- Reset (rst low, any time, including mid-word or mid-flush):
  - idx=0, flush_pend=0, acc=0, out_valid=0, data_out=0, out_cnt=0.
  - pk2s_irdy=0 and c2f_trdy=0 while rst is low.
  - Any partial word is discarded.
- Entry order is preserved; no entry is duplicated or dropped.

Test Plan (T=logic[2:0], N=4):
- Reset: assert rst=0 for 2 cycles after 2 accepted entries, then release -> pk2s_irdy=0, data_out=0, out_cnt=0, c2f_trdy=0 during reset and 1 one cycle after release; the discarded entries never appear.
- Streaming: f2c_irdy=1, s2pk_trdy=1, entries 1,2,3,4,5,6,7,0 on consecutive cycles -> c2f_trdy stays 1; words 0x8D1 (out_cnt=4) then 0x1F5 (out_cnt=4), each valid the cycle after its 4th accept.
- Backpressure: s2pk_trdy=0, feed entries 1..7 ->
  - word 0x8D1 is held stable;
  - c2f_trdy drops once idx==3 (entries 5,6,7 held);
  - raising s2pk_trdy drains 0x8D1, the 8th entry is accepted in the same cycle, and 0x1F5 follows next cycle.
- Partial flush: accept 5,6, then flush_req for 1 cycle -> c2f_trdy=0 while flush_pend; 2 cycles later data_out=0x035, out_cnt=2.
- Empty flush: flush_req with idx==0 -> flush_pend set for one cycle then cleared; no pk2s_irdy pulse.
- Flush on completing accept: flush_req in the same cycle as the 4th entry (1,2,3,4) -> exactly one word 0x8D1 with out_cnt=4; no second word; c2f_trdy returns to 1 two cycles later.
